texture_store: RTL and testbench
================================

// Module: texture_store
// PURPOSE
// - Clocked, loadable wall-texture store; replaces the sim-populated combinational texture ROM.
// - Holds NUM_TEX square textures of 2^TEX_LOG2 x 2^TEX_LOG2 texels, XRGB packed.
// - Loaded at runtime from a byte stream (from the SPI/host loader).
// - Serves texel lookups from the row renderer with fixed 2-cycle latency.
// PARAMETERS
// - CHANNEL_BITS  2  bits per R/G/B channel; texel width DW = 3*CHANNEL_BITS
// - TEX_LOG2      6  log2 of texture edge; col/row width
// - NUM_TEX       2  number of textures; TW = $clog2(NUM_TEX), min 1; need not be a power of 2
// PORTS
// - clk       in   1         system clock
// - reset_n   in   1         asynchronous active-low reset
// - ld_start  in   1         pulse: begin (or restart) full load at texel 0
// - ld_valid  in   1         ld_data holds one texel; accepted when ld_valid & ld_ready
// - ld_data   in   8         texel in [DW-1:0]; upper bits ignored
// - ld_ready  out  1         high while in LOAD
// - ld_done   out  1         one-cycle pulse after the last texel is written
// - rd_req    in   1         lookup request, one per cycle max
// - rd_tex    in   TW        texture index
// - rd_col    in   TEX_LOG2  texel column (u)
// - rd_row    in   TEX_LOG2  texel row (v)
// - rd_valid  out  1         rd_req delayed exactly 2 cycles
// - rd_val    out  DW        texel result, qualified by rd_valid
// - ready     out  1         high in READY: store holds a complete image
// BEHAVIOUR
// - Reset (async): state=EMPTY; ld_ready=0, ld_done=0, rd_valid=0, rd_val=0, ready=0; load ctr=0.
//   Memory contents are not reset.
// - Addressing: addr = {rd_tex, rd_col, rd_row}, column-major (row varies fastest).
//   Load writes texels in the same order: ctr 0 -> tex0,col0,row0; ctr 1 -> row1; ...
// - FSM:
//   - EMPTY -ld_start-> LOAD
//   - LOAD  -last texel accepted-> READY
//   - READY -ld_start-> LOAD
//   - LOAD  -ld_start-> LOAD, with ctr reset to 0.
// - LOAD:
//   - Each accepted beat writes mem[ctr] and increments ctr.
//   - On the beat with ctr == NUM_TEX*2^(2*TEX_LOG2)-1: write, ctr wraps to 0, ld_done=1
//     next cycle, enter READY.
//   - ld_start together with ld_valid in the same cycle: restart wins; that beat is dropped.
// - Read pipeline: rd_valid follows rd_req exactly 2 cycles later, in every state.
//   - Cycle N: request sampled.
//   - Cycle N+1: synchronous memory read.
//   - Cycle N+2: output register.
//   - Back-to-back requests give one result per cycle.
// - rd_val is forced to 0 if the request was sampled while not READY, or if rd_tex >= NUM_TEX.
// - Reads during LOAD never return partially loaded data; renderer timing is unchanged.
// - rd_val holds its last value when rd_valid=0.
// - Reset asserted mid-load or mid-read: pipeline is flushed immediately, state=EMPTY.
//   A full reload is required.
// CONFIGURATION
// - TEXTURE_SIDE_SHADE_EN defined:
//   - Adds input rd_side (1 bit, sampled with rd_req).
//   - When rd_side=1, each channel of rd_val is shifted right by 1 (halved) in the output stage.
//   - Latency stays 2 cycles.
// - TEXTURE_SIDE_SHADE_EN undefined: the rd_side port is absent; texels pass through unmodified.
// TESTING (CHANNEL_BITS=2, TEX_LOG2=2, NUM_TEX=2 -> 32 texels)
// - Reset, then rd_req with any address -> rd_valid=1 two cycles later, rd_val=0, ready=0.
// - ld_start, then 32 beats with data = ctr
//   -> ld_done pulses once after beat 31; ready=1.
//   - Read tex1,col2,row3 (addr 27) -> rd_val=6'h1B at N+2.
// - Load image with stalls (ld_valid toggling every other cycle)
//   -> identical contents; stalls do not advance ctr.
// - ld_start at beat 10 of a load -> ctr restarts at 0; ld_done only after 32 further beats;
//   reads meanwhile return 0.
// - Back-to-back reads of addrs 0..31 -> 32 consecutive rd_valid cycles, data in order.
// - With TEXTURE_SIDE_SHADE_EN: texel 6'h3F, rd_side=1 -> 6'h15; rd_side=0 -> 6'h3F.

Source files
------------

// File: rtl/texture_store.sv
// Loadable wall-texture store: byte-stream loader plus a 2-cycle texel lookup pipeline.
// Optional build macro TEXTURE_SIDE_SHADE_EN adds rd_side, which halves each channel.
module texture_store #(
    parameter int unsigned CHANNEL_BITS = 2,
    parameter int unsigned TEX_LOG2     = 6,
    parameter int unsigned NUM_TEX      = 2,
    localparam int unsigned DW          = 3 * CHANNEL_BITS,
    localparam int unsigned TW          = (NUM_TEX > 1) ? $clog2(NUM_TEX) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [7:0]          ld_data,
    output logic                ld_ready,
    output logic                ld_done,
    input  logic                rd_req,
    input  logic [TW-1:0]       rd_tex,
    input  logic [TEX_LOG2-1:0] rd_col,
    input  logic [TEX_LOG2-1:0] rd_row,
`ifdef TEXTURE_SIDE_SHADE_EN
    input  logic                rd_side,
`endif
    output logic                rd_valid,
    output logic [DW-1:0]       rd_val,
    output logic                ready
);

    localparam int unsigned AW        = TW + 2 * TEX_LOG2;
    localparam int unsigned DEPTH     = NUM_TEX << (2 * TEX_LOG2);
    localparam int unsigned MEM_WORDS = 1 << AW;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [TW:0] TEX_LIMIT = (TW + 1)'(NUM_TEX);

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StReady
    } state_e;

    state_e        state_q;
    logic [AW-1:0] ctr_q;
    logic          ld_ready_q;
    logic          ld_done_q;
    logic          ready_q;

    // A beat that coincides with ld_start is dropped: the restart wins.
    logic wr_en;
    assign wr_en = (state_q == StLoad) && ld_valid && !ld_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StEmpty;
            ctr_q      <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                StEmpty, StReady: begin
                    if (ld_start) begin
                        state_q    <= StLoad;
                        ctr_q      <= '0;
                        ld_ready_q <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                StLoad: begin
                    if (ld_start) begin
                        ctr_q <= '0;
                    end else if (ld_valid) begin
                        if (ctr_q == LAST) begin
                            state_q    <= StReady;
                            ctr_q      <= '0;
                            ld_ready_q <= 1'b0;
                            ld_done_q  <= 1'b1;
                            ready_q    <= 1'b1;
                        end else begin
                            ctr_q <= ctr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    ctr_q      <= '0;
                    ld_ready_q <= 1'b0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready = ld_ready_q;
    assign ld_done  = ld_done_q;
    assign ready    = ready_q;

    // Storage is not reset; the ready gating hides stale contents.
    logic [DW-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ctr_q] <= ld_data[DW-1:0];
        end
    end

    if (DW < 8) begin : g_unused_ld
        logic unused_ld_bits;
        assign unused_ld_bits = ^ld_data[7:DW];
    end

    // Stage 1: sample request, address and whether it may see stored data.
    logic          req1_q;
    logic          ok1_q;
    logic [AW-1:0] addr1_q;
    logic          rd_ok;
`ifdef TEXTURE_SIDE_SHADE_EN
    logic          side1_q;
`endif

    assign rd_ok = (state_q == StReady) && ({1'b0, rd_tex} < TEX_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req1_q  <= 1'b0;
            ok1_q   <= 1'b0;
            addr1_q <= '0;
`ifdef TEXTURE_SIDE_SHADE_EN
            side1_q <= 1'b0;
`endif
        end else begin
            req1_q <= rd_req;
            if (rd_req) begin
                ok1_q   <= rd_ok;
                addr1_q <= rd_ok ? {rd_tex, rd_col, rd_row} : '0;
`ifdef TEXTURE_SIDE_SHADE_EN
                side1_q <= rd_side;
`endif
            end
        end
    end

`ifdef TEXTURE_SIDE_SHADE_EN
    function automatic logic [DW-1:0] halve(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c*CHANNEL_BITS +: CHANNEL_BITS] = v[c*CHANNEL_BITS +: CHANNEL_BITS] >> 1;
        end
        return r;
    endfunction
`endif

    logic [DW-1:0] rd_word;

    always_comb begin
        rd_word = mem[addr1_q];
`ifdef TEXTURE_SIDE_SHADE_EN
        if (side1_q) begin
            rd_word = halve(rd_word);
        end
`endif
    end

    // Stage 2: output register; rd_val holds between results.
    logic          rd_valid_q;
    logic [DW-1:0] rd_val_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_val_q   <= '0;
        end else begin
            rd_valid_q <= req1_q;
            if (req1_q) begin
                rd_val_q <= ok1_q ? rd_word : '0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_val   = rd_val_q;

endmodule

// File: tb/tb_texture_store.sv
// Directed-sequence bench for texture_store (2 textures of 4x4 texels) with random data and
// a behavioural image model; rd_side is exercised when TEXTURE_SIDE_SHADE_EN is defined.
module tb_texture_store;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       rd_req;
    logic [0:0] rd_tex;
    logic [1:0] rd_col;
    logic [1:0] rd_row;
    logic       rd_side;
    logic       rd_valid;
    logic [5:0] rd_val;
    logic       ready;

    texture_store #(
        .CHANNEL_BITS(2),
        .TEX_LOG2    (2),
        .NUM_TEX     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ld_start(ld_start),
        .ld_valid(ld_valid),
        .ld_data (ld_data),
        .ld_ready(ld_ready),
        .ld_done (ld_done),
        .rd_req  (rd_req),
        .rd_tex  (rd_tex),
        .rd_col  (rd_col),
        .rd_row  (rd_row),
`ifdef TEXTURE_SIDE_SHADE_EN
        .rd_side (rd_side),
`endif
        .rd_valid(rd_valid),
        .rd_val  (rd_val),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Model: the last fully loaded image and whether one is currently readable.
    logic [5:0] img [N];
    logic [5:0] nxt [N];
    bit         img_ok = 1'b0;

    always @(negedge clk) if (ld_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] shade(input logic [5:0] v, input logic s);
        int r;
        r = int'(v);
`ifdef TEXTURE_SIDE_SHADE_EN
        if (s) begin
            r = 0;
            for (int c = 0; c < 3; c++) r += (((int'(v) >> (2 * c)) % 4) / 2) << (2 * c);
        end
`endif
        return 6'(r);
    endfunction

    function automatic logic [5:0] expect_read(input int tex, input int col, input int row,
                                              input logic s);
        if (!img_ok || tex >= 2) return 6'h00;
        return shade(img[tex * 16 + col * 4 + row], s);
    endfunction

    task automatic do_read(input int tex, input int col, input int row, input logic s);
        logic [5:0] exp;
        exp = expect_read(tex, col, row, s);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_tex  = 1'(tex);
        rd_col  = 2'(col);
        rd_row  = 2'(row);
        rd_side = s;
        @(posedge clk); #1;
        check("rd_valid_early", rd_valid, 0);
        @(negedge clk);
        rd_req = 1'b0;
        rd_col = 2'($urandom);
        rd_row = 2'($urandom);
        rd_side = 1'($urandom);
        @(posedge clk); #1;
        check("rd_valid", rd_valid, 1);
        check("rd_val", rd_val, exp);
    endtask

    task automatic start_load();
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = 1'b0;
        img_ok   = 1'b0;
        @(posedge clk); #1;
        check("ld_ready_on_start", ld_ready, 1);
        check("ready_on_start", ready, 0);
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic beat(input logic [5:0] d, input bit stall);
        if (stall) begin
            @(negedge clk);
            ld_valid = 1'b0;
            ld_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = {2'($urandom), d};
        @(posedge clk); #1;
    endtask

    // Streams nxt[] as a full image after the load has already been started.
    task automatic stream_image(input bit stall);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < N; i++) begin
            beat(nxt[i], stall && (i % 2 == 1));
            if (i == N - 2) check("no_early_done", done_cnt - d0, 0);
        end
        check("ld_done_pulse", ld_done, 1);
        check("ready_after_load", ready, 1);
        check("ld_ready_after_load", ld_ready, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        @(posedge clk); #1;
        check("ld_done_cleared", ld_done, 0);
        check("ld_done_count", done_cnt - d0, 1);
        for (int i = 0; i < N; i++) img[i] = nxt[i];
        img_ok = 1'b1;
    endtask

    task automatic random_reads(input int n);
        for (int k = 0; k < n; k++) begin
            do_read(int'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom));
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        rd_req   = 1'b0;
        rd_tex   = '0;
        rd_col   = '0;
        rd_row   = '0;
        rd_side  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_val", rd_val, 0);
        check("rst_ready", ready, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Read while empty: valid arrives, data is zero.
        do_read(1, 2, 3, 1'b0);
        check("empty_ready", ready, 0);

        // Load with data = ctr, then the addr-27 lookup.
        for (int i = 0; i < N; i++) nxt[i] = 6'(i);
        start_load();
        stream_image(1'b0);
        do_read(1, 2, 3, 1'b0);
        check("addr27_const", rd_val, 6'h1B);

        // Random image with stalls on every other beat.
        for (int i = 0; i < N; i++) nxt[i] = 6'($urandom);
        nxt[5] = 6'h3F;
        start_load();
        stream_image(1'b1);
        random_reads(8);
`ifdef TEXTURE_SIDE_SHADE_EN
        do_read(0, 1, 1, 1'b1);
        check("shade_on", rd_val, 6'h15);
        do_read(0, 1, 1, 1'b0);
        check("shade_off", rd_val, 6'h3F);
`endif

        // Restart at beat 10; the coincident beat must be dropped.
        for (int i = 0; i < N; i++) nxt[i] = 6'($urandom);
        start_load();
        for (int i = 0; i < 10; i++) beat(6'($urandom), 1'b0);
        @(negedge clk);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h2A;
        @(posedge clk); #1;
        check("restart_ld_ready", ld_ready, 1);
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        do_read(int'($urandom_range(1, 0)), 1, 2, 1'b0);
        check("restart_ready", ready, 0);
        stream_image(1'b0);
        do_read(0, 0, 0, 1'b0);
        random_reads(6);

        // Back-to-back reads of every address.
        rd_side = 1'b0;
        for (int cyc = 0; cyc <= N; cyc++) begin
            @(negedge clk);
            if (cyc < N) begin
                rd_req = 1'b1;
                {rd_tex, rd_col, rd_row} = 5'(cyc);
            end else begin
                rd_req = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc >= 1) begin
                check("b2b_valid", rd_valid, 1);
                check("b2b_val", rd_val, img[cyc - 1]);
            end
        end
        @(posedge clk); #1;
        check("b2b_tail", rd_valid, 0);

        // Reset mid-load with a read in flight.
        start_load();
        for (int i = 0; i < 5; i++) beat(6'($urandom), 1'b0);
        @(negedge clk);
        ld_valid = 1'b0;
        rd_req   = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_ld_ready", ld_ready, 0);
        check("mid_rst_ready", ready, 0);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        img_ok  = 1'b0;
        @(posedge clk); #1;
        check("post_rst_flushed", rd_valid, 0);
        do_read(1, 3, 0, 1'b0);
        check("post_rst_ready", ready, 0);

        // Full reload after reset.
        for (int i = 0; i < N; i++) nxt[i] = 6'($urandom);
        start_load();
        stream_image(1'b1);
        random_reads(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
